// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - opcodes, issue FSM states and register-use decode for issue_ctrl
package issue_ctrl_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] U_LUI       = 7'b0110111;
  localparam logic [6:0] U_AUIPC     = 7'b0010111;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT_BR = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
  } reg_use_t;

  // Unknown opcodes use no registers, so they issue as NOPs.
  function automatic reg_use_t decode_use(input logic [6:0] opc);
    reg_use_t u;
    u = '0;
    case (opc)
      R_TYPE:              u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
      I_TYPE, I_TYPE_LOAD: u = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
      S_TYPE, B_TYPE:      u = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
      U_LUI, U_AUIPC:      u = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
      default:             u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// rtl/issue_ctrl_if.sv - fetch/issue/writeback/branch signal bundle for issue_ctrl
interface issue_ctrl_if;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        issue_valid;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        br_resolve;
  logic        br_taken;
  logic        flush;
  logic [31:0] stall_cnt;

  modport master (
    output fetch_valid, fetch_instr, issue_ready, wb_valid, wb_rd, br_resolve, br_taken,
    input  fetch_ready, issue_valid, flush, stall_cnt
  );

  modport slave (
    input  fetch_valid, fetch_instr, issue_ready, wb_valid, wb_rd, br_resolve, br_taken,
    output fetch_ready, issue_valid, flush, stall_cnt
  );
endinterface

// File: rtl/issue_ctrl_reg_scoreboard.sv
// rtl/issue_ctrl_reg_scoreboard.sv - 32-entry pending-write vector, x0 never pending
module reg_scoreboard
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] pend
);

  logic [31:0] pend_d;
  logic [31:0] pend_q;

  // Clear is applied first so a same-cycle set on the same bit wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_idx] = 1'b0;
    if (set_en) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order RV32I issue controller with register scoreboard and branch serialisation
// Optional ISSUE_WB_BYPASS_EN: hazard check ignores the register being written back this cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  issue_ctrl_if.slave  bus
);

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  reg_use_t    use_r;
  logic [31:0] pend;
  logic [31:0] pend_view;
  logic        hz;
  logic        issue_valid, fetch_ready, flush;
  logic        set_en;
  state_e      state_d, state_q;
  logic [31:0] stall_d, stall_q;
  logic        unused_instr_bits;

  assign opc   = bus.fetch_instr[6:0];
  assign rd    = bus.fetch_instr[11:7];
  assign rs1   = bus.fetch_instr[19:15];
  assign rs2   = bus.fetch_instr[24:20];
  assign use_r = decode_use(opc);
  assign unused_instr_bits = ^{bus.fetch_instr[31:25], bus.fetch_instr[14:12]};

  assign set_en = issue_valid & bus.issue_ready & use_r.rd;

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en),
    .set_idx (rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .pend    (pend)
  );

  always_comb begin
    pend_view = pend;
`ifdef ISSUE_WB_BYPASS_EN
    if (bus.wb_valid) pend_view[bus.wb_rd] = 1'b0;
`endif
  end

  // rd is checked too so a second writer waits for the first (WAW).
  assign hz = (use_r.rs1 & pend_view[rs1]) |
              (use_r.rs2 & pend_view[rs2]) |
              (use_r.rd  & pend_view[rd]);

  always_comb begin
    issue_valid = 1'b0;
    fetch_ready = 1'b0;
    flush       = 1'b0;
    state_d     = state_q;
    case (state_q)
      ISSUE: begin
        issue_valid = bus.fetch_valid & ~hz;
        fetch_ready = issue_valid & bus.issue_ready;
        if (fetch_ready && opc == B_TYPE) state_d = WAIT_BR;
      end
      WAIT_BR: begin
        if (bus.br_resolve) state_d = bus.br_taken ? FLUSH : ISSUE;
      end
      FLUSH: begin
        flush       = 1'b1;
        fetch_ready = 1'b1;
        state_d     = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.fetch_valid && !fetch_ready && state_q != FLUSH) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISSUE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign bus.issue_valid = issue_valid;
  assign bus.fetch_ready = fetch_ready;
  assign bus.flush       = flush;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl with an issue-order scoreboard
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

`ifdef ISSUE_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  issue_ctrl_if bus();

  issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, R_TYPE};
  endfunction
  function automatic logic [31:0] i_ins(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] s_ins(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, S_TYPE};
  endfunction
  function automatic logic [31:0] b_ins(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, 5'd0, B_TYPE};
  endfunction

  // Every issue handshake must match the oldest instruction the bench expects to issue.
  always @(negedge clk) begin
    if (rst_n && bus.issue_valid && bus.issue_ready) begin
      if (exp_q.size() == 0) chk("issue_unexpected", bus.fetch_instr, 32'hxxxx_xxxx);
      else chk("issue_instr", bus.fetch_instr, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_after(input int n, input logic [4:0] rd);
    repeat (n) step();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    step();
    bus.wb_valid = 1'b0;
  endtask

  task automatic issue_wait(input logic [31:0] instr, output int waited);
    bit done;
    done    = 1'b0;
    waited  = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = instr;
    exp_q.push_back(instr);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.issue_valid && bus.issue_ready) begin
        done = 1'b1;
        break;
      end
      waited++;
      step();
    end
    chk("issue_timeout", {31'd0, done}, 32'd1);
    step();
    bus.fetch_valid = 1'b0;
  endtask

  initial begin
    int w;
    int exp_stall;
    logic [31:0] nop;
    nop = i_ins(I_TYPE, 3'b000, 5'd0, 5'd0, 12'd0);
    exp_stall = 0;

    rst_n = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.issue_ready = 1'b1;
    bus.wb_valid    = 1'b0;
    bus.wb_rd       = '0;
    bus.br_resolve  = 1'b0;
    bus.br_taken    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_pend", dut.u_sb.pend_q, 32'd0);
    step();
    rst_n = 1'b1;

    issue_wait(i_ins(I_TYPE, 3'b000, 5'd5, 5'd0, 12'd1), w);
    chk("addi_wait", w, 0);
    chk("addi_pend", dut.u_sb.pend_q, 32'h0000_0020);
    chk("addi_stall_cnt", bus.stall_cnt, 32'd0);

    fork wb_after(2, 5'd5); join_none
    issue_wait(r_ins(5'd6, 5'd5, 5'd5), w);
    chk("raw_wait", w, 3 - BYP);
    exp_stall += 3 - BYP;
    chk("raw_stall_cnt", bus.stall_cnt, exp_stall);
    chk("raw_pend", dut.u_sb.pend_q, 32'h0000_0040);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd6;
    step();
    bus.wb_valid = 1'b0;
    chk("wb6_pend", dut.u_sb.pend_q, 32'd0);

    issue_wait(i_ins(I_TYPE_LOAD, 3'b010, 5'd7, 5'd0, 12'd0), w);
    chk("lw1_wait", w, 0);
    fork wb_after(3, 5'd7); join_none
    issue_wait(i_ins(I_TYPE_LOAD, 3'b010, 5'd7, 5'd0, 12'd4), w);
    chk("waw_wait", w, 4 - BYP);
    exp_stall += 4 - BYP;
    chk("waw_stall_cnt", bus.stall_cnt, exp_stall);
    chk("waw_pend", dut.u_sb.pend_q, 32'h0000_0080);
    issue_wait(s_ins(5'd0, 5'd0), w);
    chk("sw_x0_wait", w, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    step();
    bus.wb_valid = 1'b0;

    issue_wait(b_ins(3'b000, 5'd1, 5'd2), w);
    chk("beq_wait", w, 0);
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = i_ins(I_TYPE, 3'b000, 5'd3, 5'd0, 12'd9);
    @(negedge clk);
    chk("wbr_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
    chk("wbr_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    step();
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b1;
    @(negedge clk);
    chk("wbr_fetch_ready2", {31'd0, bus.fetch_ready}, 32'd0);
    step();
    bus.br_resolve = 1'b0;
    @(negedge clk);
    chk("flush_pulse", {31'd0, bus.flush}, 32'd1);
    chk("flush_fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
    chk("flush_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    step();
    bus.fetch_valid = 1'b0;
    chk("post_flush_flush", {31'd0, bus.flush}, 32'd0);
    issue_wait(nop, w);
    chk("post_flush_wait", w, 0);
    exp_stall += 2;
    chk("br_stall_cnt", bus.stall_cnt, exp_stall);
    chk("post_flush_pend", dut.u_sb.pend_q, 32'd0);

    issue_wait(b_ins(3'b001, 5'd1, 5'd2), w);
    chk("bne_wait", w, 0);
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b0;
    @(negedge clk);
    chk("bne_state_wbr", {30'd0, dut.state_q}, {30'd0, WAIT_BR});
    step();
    bus.br_resolve = 1'b0;
    @(negedge clk);
    chk("bne_no_flush", {31'd0, bus.flush}, 32'd0);
    chk("bne_state_issue", {30'd0, dut.state_q}, {30'd0, ISSUE});
    step();
    bus.br_resolve = 1'b1;
    bus.br_taken   = 1'b1;
    @(negedge clk);
    chk("stray_no_flush", {31'd0, bus.flush}, 32'd0);
    step();
    bus.br_resolve = 1'b0;
    chk("stray_state", {30'd0, dut.state_q}, {30'd0, ISSUE});
    issue_wait(nop, w);
    chk("stray_wait", w, 0);

    issue_wait(i_ins(I_TYPE_LOAD, 3'b010, 5'd5, 5'd0, 12'd0), w);
    issue_wait(i_ins(I_TYPE_LOAD, 3'b010, 5'd7, 5'd0, 12'd0), w);
    issue_wait(b_ins(3'b000, 5'd0, 5'd0), w);
    chk("midbr_pend", dut.u_sb.pend_q, 32'h0000_00A0);
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = nop;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midbr_rst_pend", dut.u_sb.pend_q, 32'd0);
    chk("midbr_rst_state", {30'd0, dut.state_q}, {30'd0, ISSUE});
    chk("midbr_rst_stall", bus.stall_cnt, 32'd0);
    bus.fetch_valid = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_flush", {31'd0, bus.flush}, 32'd0);
    chk("rel_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
